// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control path: opcodes, T-state encodings and
// control-word bit positions.
package sap_pkg;

   localparam int OP_BITS   = 4;
   localparam int STEP_BITS = 3;

   localparam logic [OP_BITS-1:0] OP_NOP = 4'h0;
   localparam logic [OP_BITS-1:0] OP_LDA = 4'h1;
   localparam logic [OP_BITS-1:0] OP_ADD = 4'h2;
   localparam logic [OP_BITS-1:0] OP_SUB = 4'h3;
   localparam logic [OP_BITS-1:0] OP_STA = 4'h4;
   localparam logic [OP_BITS-1:0] OP_LDI = 4'h5;
   localparam logic [OP_BITS-1:0] OP_JMP = 4'h6;
   localparam logic [OP_BITS-1:0] OP_JC  = 4'h7;
   localparam logic [OP_BITS-1:0] OP_JZ  = 4'h8;
   localparam logic [OP_BITS-1:0] OP_OUT = 4'hE;
   localparam logic [OP_BITS-1:0] OP_HLT = 4'hF;

   localparam logic [STEP_BITS-1:0] T0 = 3'd0;
   localparam logic [STEP_BITS-1:0] T1 = 3'd1;
   localparam logic [STEP_BITS-1:0] T2 = 3'd2;
   localparam logic [STEP_BITS-1:0] T3 = 3'd3;
   localparam logic [STEP_BITS-1:0] T4 = 3'd4;

   localparam int CW_PC_OUT   = 0;
   localparam int CW_PC_INC   = 1;
   localparam int CW_PC_LOAD  = 2;
   localparam int CW_MAR_IN   = 3;
   localparam int CW_RAM_OUT  = 4;
   localparam int CW_RAM_IN   = 5;
   localparam int CW_IR_IN    = 6;
   localparam int CW_IR_OUT   = 7;
   localparam int CW_A_IN     = 8;
   localparam int CW_A_OUT    = 9;
   localparam int CW_B_IN     = 10;
   localparam int CW_ALU_OUT  = 11;
   localparam int CW_ALU_SUB  = 12;
   localparam int CW_FLAGS_IN = 13;
   localparam int CW_OUT_IN   = 14;
   localparam int CW_W        = 15;

   typedef logic [CW_W-1:0] cw_t;

   function automatic cw_t cw_bit(input int idx);
      cw_bit = cw_t'(1) << idx;
   endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: maps (T-state, opcode, flags) to a control word,
// the last-step marker and the halt request. No state, no latency.
module sap_microcode_rom
   import sap_pkg::*;
(
   input  logic [STEP_BITS-1:0] step_i,
   input  logic [OP_BITS-1:0]   opcode_i,
   input  logic                 carry_flag_i,
   input  logic                 zero_flag_i,
   output cw_t                  cw_o,
   output logic                 last_step_o,
   output logic                 do_halt_o
);

   always_comb begin
      cw_o        = '0;
      last_step_o = 1'b0;
      do_halt_o   = 1'b0;
      case (step_i)
         T0: cw_o = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_IN);
         T1: cw_o = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_IN) | cw_bit(CW_PC_INC);
         T2: begin
            last_step_o = 1'b1;
            case (opcode_i)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  cw_o        = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
                  last_step_o = 1'b0;
               end
               OP_LDI: cw_o = cw_bit(CW_IR_OUT) | cw_bit(CW_A_IN);
               OP_JMP: cw_o = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
               OP_JC:  if (carry_flag_i) cw_o = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
               OP_JZ:  if (zero_flag_i)  cw_o = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
               OP_OUT: cw_o = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_IN);
               OP_HLT: do_halt_o = 1'b1;
               default: cw_o = '0;
            endcase
         end
         T3: begin
            last_step_o = 1'b1;
            case (opcode_i)
               OP_LDA: cw_o = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_IN);
               OP_STA: cw_o = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_IN);
               OP_ADD, OP_SUB: begin
                  cw_o        = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_IN);
                  last_step_o = 1'b0;
               end
               default: cw_o = '0;
            endcase
         end
         T4: begin
            last_step_o = 1'b1;
            if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               cw_o = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN) | cw_bit(CW_FLAGS_IN);
               if (opcode_i == OP_SUB) cw_o = cw_o | cw_bit(CW_ALU_SUB);
            end
         end
         // encodings above T4 are never entered normally; fall back to fetch
         default: last_step_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// SAP control unit: step and halted registers around the microcode ROM.
// Strobes are combinational from the current step; run=0 freezes and blanks them.
module control_sequencer
   import sap_pkg::*;
#(
   parameter int OP_W   = OP_BITS,
   parameter int STEP_W = STEP_BITS
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [OP_W-1:0]   opcode,
   input  logic              carry_flag,
   input  logic              zero_flag,
   output logic              pc_out,
   output logic              pc_inc,
   output logic              pc_load,
   output logic              mar_in,
   output logic              ram_out,
   output logic              ram_in,
   output logic              ir_in,
   output logic              ir_out,
   output logic              a_in,
   output logic              a_out,
   output logic              b_in,
   output logic              alu_out,
   output logic              alu_sub,
   output logic              flags_in,
   output logic              out_in,
   output logic              halted,
   output logic [STEP_W-1:0] step
);

   logic [STEP_W-1:0] step_q, step_d;
   logic              halted_q, halted_d;
   cw_t               cw_rom, cw_gated;
   logic              last_step, do_halt, active;

   sap_microcode_rom u_rom (
      .step_i       (step_q),
      .opcode_i     (opcode),
      .carry_flag_i (carry_flag),
      .zero_flag_i  (zero_flag),
      .cw_o         (cw_rom),
      .last_step_o  (last_step),
      .do_halt_o    (do_halt)
   );

   assign active = run & ~halted_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (active) begin
         step_d = last_step ? T0 : step_q + STEP_W'(1);
         if (do_halt) halted_d = 1'b1;
      end
   end

   // rst blanks the word immediately, without waiting for an edge
   always_comb begin
      cw_gated = '0;
      if (active && !rst) cw_gated = cw_rom;
   end

   assign pc_out   = cw_gated[CW_PC_OUT];
   assign pc_inc   = cw_gated[CW_PC_INC];
   assign pc_load  = cw_gated[CW_PC_LOAD];
   assign mar_in   = cw_gated[CW_MAR_IN];
   assign ram_out  = cw_gated[CW_RAM_OUT];
   assign ram_in   = cw_gated[CW_RAM_IN];
   assign ir_in    = cw_gated[CW_IR_IN];
   assign ir_out   = cw_gated[CW_IR_OUT];
   assign a_in     = cw_gated[CW_A_IN];
   assign a_out    = cw_gated[CW_A_OUT];
   assign b_in     = cw_gated[CW_B_IN];
   assign alu_out  = cw_gated[CW_ALU_OUT];
   assign alu_sub  = cw_gated[CW_ALU_SUB];
   assign flags_in = cw_gated[CW_FLAGS_IN];
   assign out_in   = cw_gated[CW_OUT_IN];
   assign halted   = halted_q;
   assign step     = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: an instruction-level model pushes the
// expected strobes/step/halted per cycle; a negedge monitor pops and compares.
module tb_control_sequencer;

   localparam logic [14:0] M_PC_OUT   = 15'h0001;
   localparam logic [14:0] M_PC_INC   = 15'h0002;
   localparam logic [14:0] M_PC_LOAD  = 15'h0004;
   localparam logic [14:0] M_MAR_IN   = 15'h0008;
   localparam logic [14:0] M_RAM_OUT  = 15'h0010;
   localparam logic [14:0] M_RAM_IN   = 15'h0020;
   localparam logic [14:0] M_IR_IN    = 15'h0040;
   localparam logic [14:0] M_IR_OUT   = 15'h0080;
   localparam logic [14:0] M_A_IN     = 15'h0100;
   localparam logic [14:0] M_A_OUT    = 15'h0200;
   localparam logic [14:0] M_B_IN     = 15'h0400;
   localparam logic [14:0] M_ALU_OUT  = 15'h0800;
   localparam logic [14:0] M_ALU_SUB  = 15'h1000;
   localparam logic [14:0] M_FLAGS_IN = 15'h2000;
   localparam logic [14:0] M_OUT_IN   = 15'h4000;
   localparam logic [14:0] M_DRIVERS  = M_PC_OUT | M_RAM_OUT | M_IR_OUT | M_A_OUT | M_ALU_OUT;

   typedef struct {
      logic [14:0] cw;
      int          step;
      logic        halted;
      int          tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic       carry_flag = 1'b0;
   logic       zero_flag = 1'b0;
   logic pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
   logic a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halted;
   logic [2:0] step;

   control_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode),
      .carry_flag(carry_flag), .zero_flag(zero_flag),
      .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
      .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
      .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
      .alu_sub(alu_sub), .flags_in(flags_in), .out_in(out_in),
      .halted(halted), .step(step)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   cur_tag = 0;

   // model state: position within the current instruction, sticky halt
   int   m_pos = 0;
   bit   m_halted = 1'b0;
   bit   cur_rst = 1'b1, cur_run = 1'b0, cur_c = 1'b0, cur_z = 1'b0;
   logic [3:0] cur_op = 4'h0;

   function automatic int instr_len(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         default:    return 3;
      endcase
   endfunction

   function automatic logic [14:0] exp_cw(input int pos, input logic [3:0] op, input bit c, input bit z);
      logic [14:0] mem_addr_from_ir;
      mem_addr_from_ir = M_IR_OUT | M_MAR_IN;
      if (pos == 0) return M_PC_OUT | M_MAR_IN;
      if (pos == 1) return M_RAM_OUT | M_IR_IN | M_PC_INC;
      case (op)
         4'h1: return (pos == 2) ? mem_addr_from_ir : M_RAM_OUT | M_A_IN;
         4'h2: return (pos == 2) ? mem_addr_from_ir : (pos == 3) ? M_RAM_OUT | M_B_IN
                                 : M_ALU_OUT | M_A_IN | M_FLAGS_IN;
         4'h3: return (pos == 2) ? mem_addr_from_ir : (pos == 3) ? M_RAM_OUT | M_B_IN
                                 : M_ALU_OUT | M_A_IN | M_FLAGS_IN | M_ALU_SUB;
         4'h4: return (pos == 2) ? mem_addr_from_ir : M_A_OUT | M_RAM_IN;
         4'h5: return M_IR_OUT | M_A_IN;
         4'h6: return M_IR_OUT | M_PC_LOAD;
         4'h7: return c ? (M_IR_OUT | M_PC_LOAD) : 15'h0;
         4'h8: return z ? (M_IR_OUT | M_PC_LOAD) : 15'h0;
         4'hE: return M_A_OUT | M_OUT_IN;
         default: return 15'h0;
      endcase
   endfunction

   task automatic model_edge();
      if (cur_rst) begin
         m_pos    = 0;
         m_halted = 1'b0;
      end else if (cur_run && !m_halted) begin
         if (cur_op == 4'hF && m_pos == 2) m_halted = 1'b1;
         m_pos = (m_pos + 1 >= instr_len(cur_op)) ? 0 : m_pos + 1;
      end
   endtask

   task automatic cyc(input bit r, input bit rn, input logic [3:0] op, input bit c, input bit z);
      exp_t e;
      @(posedge clk);
      model_edge();
      #1;
      rst = r; run = rn; opcode = op; carry_flag = c; zero_flag = z;
      cur_rst = r; cur_run = rn; cur_op = op; cur_c = c; cur_z = z;
      e.cw     = (r || !rn || m_halted) ? 15'h0 : exp_cw(m_pos, op, c, z);
      e.step   = r ? 0 : m_pos;
      e.halted = r ? 1'b0 : m_halted;
      e.tag    = cur_tag;
      sb.push_back(e);
   endtask

   task automatic stall_cycles(input int n);
      for (int k = 0; k < n; k++)
         cyc(1'b0, 1'b0, 4'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // one instruction; fetch cycles see garbage opcode/flags, execute holds op
   task automatic run_instr(input logic [3:0] op, input bit c, input bit z, input bit rnd_stall);
      int n;
      n = instr_len(op);
      for (int p = 0; p < n; p++) begin
         if (rnd_stall && $urandom_range(0, 4) == 0) stall_cycles($urandom_range(1, 3));
         if (p < 2) cyc(1'b0, 1'b1, 4'($urandom), 1'($urandom), 1'($urandom));
         else       cyc(1'b0, 1'b1, op, c, z);
      end
   endtask

   task automatic check(input string name, input int got, input int want, input int tag);
      n_vec++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s (test %0d, t=%0t): got %0h, expected %0h", name, tag, $time, got, want);
      end
   endtask

   initial begin : monitor
      exp_t        e;
      logic [14:0] act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {out_in, flags_in, alu_sub, alu_out, b_in, a_out, a_in, ir_out,
                   ir_in, ram_in, ram_out, mar_in, pc_load, pc_inc, pc_out};
            check("strobes", int'(act), int'(e.cw), e.tag);
            check("step", int'(step), e.step, e.tag);
            check("halted", int'(halted), int'(e.halted), e.tag);
            check("one_driver", int'($countones(act & M_DRIVERS) <= 1), 1, e.tag);
         end
      end
   end

   initial begin : stim
      logic [3:0] op;
      cur_tag = 0;
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);

      // 1: reset in the middle of ADD T3, then a clean T0
      cur_tag = 1;
      cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'h9, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);

      // 2: full ADD, then SUB
      cur_tag = 2;
      run_instr(4'h2, 1'b0, 1'b0, 1'b0);
      run_instr(4'h3, 1'b1, 1'b1, 1'b0);

      // 3: JC both ways, JZ both ways
      cur_tag = 3;
      run_instr(4'h7, 1'b1, 1'b0, 1'b0);
      run_instr(4'h7, 1'b0, 1'b1, 1'b0);
      run_instr(4'h8, 1'b0, 1'b1, 1'b0);
      run_instr(4'h8, 1'b1, 1'b0, 1'b0);

      // 5: STA with run dropped for 3 clk in T3
      cur_tag = 5;
      for (int p = 0; p < 3; p++) cyc(1'b0, 1'b1, (p < 2) ? 4'h0 : 4'h4, 1'b0, 1'b0);
      for (int p = 0; p < 3; p++) cyc(1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
      run_instr(4'h0, 1'b0, 1'b0, 1'b0);

      // 6: sweep every non-halting opcode
      cur_tag = 6;
      for (int o = 0; o < 15; o++) run_instr(4'(o), 1'($urandom), 1'($urandom), 1'b0);

      // 4: HLT, 20 frozen clocks, then reset clears it
      cur_tag = 4;
      run_instr(4'hF, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) cyc(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      run_instr(4'h1, 1'b0, 1'b0, 1'b0);

      // 7: random programme with random stalls and occasional halts
      cur_tag = 7;
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom);
         if (op == 4'hF && $urandom_range(0, 2) != 0) op = 4'h2;
         run_instr(op, 1'($urandom), 1'($urandom), 1'b1);
         if (op == 4'hF) begin
            for (int k = 0; k < 4; k++) cyc(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            cyc(1'b1, 1'($urandom), 4'($urandom), 1'b0, 1'b0);
         end
      end

      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0, 99);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
